// File: rtl/dma_controller_pkg.sv
// Shared bus constants, DMA register map and FSM state type for the copy engine.
package dma_controller_pkg;
  localparam int XLEN        = 32;
  localparam int BUS_WIDTH   = 32;
  localparam int BUS_ACC_CNT = 3;
  localparam int ACC_W       = $clog2(BUS_ACC_CNT);

  localparam logic [ACC_W-1:0] BUS_ACC_1B = ACC_W'(0);
  localparam logic [ACC_W-1:0] BUS_ACC_2B = ACC_W'(1);
  localparam logic [ACC_W-1:0] BUS_ACC_4B = ACC_W'(2);

  // Register window: 16 bytes at DMA_ADDR; anything outside it faults.
  localparam logic [XLEN-1:0] DMA_ADDR     = 32'h0000_0000;
  localparam logic [XLEN-1:0] DMA_SEL_MASK = 32'hFFFF_FFF0;
  localparam int              RST_DMA      = 0;

  localparam logic [3:0] DMA_REG_SRC  = 4'h0;
  localparam logic [3:0] DMA_REG_DST  = 4'h4;
  localparam logic [3:0] DMA_REG_LEN  = 4'h8;
  localparam logic [3:0] DMA_REG_CTRL = 4'hC;

  localparam int DMA_CTRL_START = 0;
  localparam int DMA_CTRL_BUSY  = 1;
  localparam int DMA_CTRL_DONE  = 2;
  localparam int DMA_CTRL_ERR   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT
  } dma_state_e;
endpackage

// File: rtl/dma_controller_regs.sv
// Responder side of the DMA: register decode, fault/resp generation, SRC/DST/LEN storage
// and the DONE/ERR status bits.
module dma_regs
  import dma_controller_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [XLEN-1:0]      addr_i,
  input  logic                 w_rb_i,
  input  logic [ACC_W-1:0]     acc_i,
  input  logic [BUS_WIDTH-1:0] wdata_i,
  input  logic                 req_i,
  output logic [BUS_WIDTH-1:0] rdata_o,
  output logic                 resp_o,
  output logic                 fault_o,
  input  logic                 busy_i,
  input  logic                 done_set_i,
  input  logic                 err_set_i,
  output logic [XLEN-1:0]      src_o,
  output logic [XLEN-1:0]      dst_o,
  output logic [LEN_WIDTH-1:0] len_o,
  output logic                 start_o
);
  logic [XLEN-1:0]      src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 done_q, done_d, err_q, err_d, resp_q;
  logic [BUS_WIDTH-1:0] rdata_q, rd_val;
  logic [3:0]           off;
  logic                 in_win, ok, wr_en, wr_ctrl, start_req;

  assign off     = addr_i[3:0];
  assign in_win  = (addr_i & DMA_SEL_MASK) == DMA_ADDR;
  assign fault_o = req_i & ((acc_i != BUS_ACC_4B) || (off[1:0] != 2'b00) ||
                            (off > DMA_REG_CTRL) || !in_win);
  assign ok        = req_i & ~fault_o;
  assign wr_en     = ok & w_rb_i & ~busy_i;
  assign wr_ctrl   = ok & w_rb_i & (off == DMA_REG_CTRL);
  assign start_req = wr_ctrl & wdata_i[DMA_CTRL_START] & ~busy_i;
  assign start_o   = start_req & (len_q != '0);

  // Hardware set of DONE/ERR is applied last so it wins over a same-cycle w1c.
  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    len_d  = len_q;
    done_d = done_q;
    err_d  = err_q;
    if (wr_en && off == DMA_REG_SRC) src_d = wdata_i;
    if (wr_en && off == DMA_REG_DST) dst_d = wdata_i;
    if (wr_en && off == DMA_REG_LEN) len_d = wdata_i[LEN_WIDTH-1:0];
    if (wr_ctrl && wdata_i[DMA_CTRL_DONE]) done_d = 1'b0;
    if (wr_ctrl && wdata_i[DMA_CTRL_ERR])  err_d  = 1'b0;
    if (start_o) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    if (done_set_i || (start_req && len_q == '0)) done_d = 1'b1;
    if (err_set_i) err_d = 1'b1;
  end

  always_comb begin
    rd_val = '0;
    case (off)
      DMA_REG_SRC: rd_val = src_q;
      DMA_REG_DST: rd_val = dst_q;
      DMA_REG_LEN: rd_val[LEN_WIDTH-1:0] = len_q;
      DMA_REG_CTRL: begin
        rd_val[DMA_CTRL_BUSY] = busy_i;
        rd_val[DMA_CTRL_DONE] = done_q;
        rd_val[DMA_CTRL_ERR]  = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      done_q  <= done_d;
      err_q   <= err_d;
      resp_q  <= ok;
      rdata_q <= (ok & ~w_rb_i) ? rd_val : '0;
    end
  end

  assign resp_o  = resp_q;
  assign rdata_o = rdata_q;
  assign src_o   = src_q;
  assign dst_o   = dst_q;
  assign len_o   = len_q;
endmodule

// File: rtl/dma_controller.sv
// Memory-to-memory copy engine: register responder plus a bus initiator that moves LEN
// bytes from SRC to DST as read/write pairs of 4-byte or 1-byte beats.
module dma_controller
  import dma_controller_pkg::*;
#(
  parameter int TIMEOUT   = 256,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [XLEN-1:0]      addr,
  input  logic                 w_rb,
  input  logic [ACC_W-1:0]     acc,
  input  logic [BUS_WIDTH-1:0] wdata,
  output logic [BUS_WIDTH-1:0] rdata,
  input  logic                 req,
  output logic                 resp,
  output logic                 fault,
  output logic [XLEN-1:0]      dma_addr,
  output logic                 dma_w_rb,
  output logic [ACC_W-1:0]     dma_acc,
  output logic [BUS_WIDTH-1:0] dma_wdata,
  input  logic [BUS_WIDTH-1:0] dma_rdata,
  output logic                 dma_req,
  input  logic                 dma_resp
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  dma_state_e           state_q, state_d;
  logic [XLEN-1:0]      cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d, step;
  logic [BUS_WIDTH-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]     wait_q, wait_d;
  logic [XLEN-1:0]      reg_src, reg_dst;
  logic [LEN_WIDTH-1:0] reg_len;
  logic                 start, busy, done_set, err_set, word_beat, timed_out;
  logic [ACC_W-1:0]     beat_acc;

  assign busy = (state_q != ST_IDLE);

  dma_regs #(.LEN_WIDTH(LEN_WIDTH)) u_regs (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .addr_i     (addr),
    .w_rb_i     (w_rb),
    .acc_i      (acc),
    .wdata_i    (wdata),
    .req_i      (req),
    .rdata_o    (rdata),
    .resp_o     (resp),
    .fault_o    (fault),
    .busy_i     (busy),
    .done_set_i (done_set),
    .err_set_i  (err_set),
    .src_o      (reg_src),
    .dst_o      (reg_dst),
    .len_o      (reg_len),
    .start_o    (start)
  );

  // Beat size depends only on state that is frozen for the whole read/write pair.
  assign word_beat = (cur_src_q[1:0] == 2'b00) && (cur_dst_q[1:0] == 2'b00) &&
                     (rem_q >= LEN_WIDTH'(4));
  assign step      = word_beat ? LEN_WIDTH'(4) : LEN_WIDTH'(1);
  assign beat_acc  = word_beat ? BUS_ACC_4B : BUS_ACC_1B;
  assign timed_out = (wait_q >= CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    rem_d     = rem_q;
    buf_d     = buf_q;
    wait_d    = wait_q;
    done_set  = 1'b0;
    err_set   = 1'b0;
    dma_addr  = '0;
    dma_w_rb  = 1'b0;
    dma_acc   = BUS_ACC_1B;
    dma_wdata = '0;
    dma_req   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_src_d = reg_src;
          cur_dst_d = reg_dst;
          rem_d     = reg_len;
          state_d   = ST_RD_REQ;
        end
      end
      ST_RD_REQ, ST_RD_WAIT: begin
        dma_addr = cur_src_q;
        dma_acc  = beat_acc;
        if (state_q == ST_RD_REQ) begin
          dma_req = 1'b1;
          wait_d  = CNT_W'(1);
          state_d = ST_RD_WAIT;
        end else if (dma_resp) begin
          buf_d   = dma_rdata;
          state_d = ST_WR_REQ;
        end else if (timed_out) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      ST_WR_REQ, ST_WR_WAIT: begin
        dma_addr  = cur_dst_q;
        dma_w_rb  = 1'b1;
        dma_acc   = beat_acc;
        dma_wdata = buf_q;
        if (state_q == ST_WR_REQ) begin
          dma_req = 1'b1;
          wait_d  = CNT_W'(1);
          state_d = ST_WR_WAIT;
        end else if (dma_resp) begin
          cur_src_d = cur_src_q + XLEN'(step);
          cur_dst_d = cur_dst_q + XLEN'(step);
          rem_d     = rem_q - step;
          if (rem_q == step) begin
            done_set = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_RD_REQ;
          end
        end else if (timed_out) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cur_src_q <= '0;
      cur_dst_q <= '0;
      rem_q     <= '0;
      buf_q     <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      cur_src_q <= cur_src_d;
      cur_dst_q <= cur_dst_d;
      rem_q     <= rem_d;
      buf_q     <= buf_d;
      wait_q    <= wait_d;
    end
  end
endmodule
